// File: rtl/filter_pkg.sv
// Shared definitions for the masked 2D filter top: default widths, the
// output-streamer state encoding and the UART command bytes.
package filter_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DIM_W  = 8;
    localparam int unsigned DEF_ADDR_W = 16;

    // Header states exist in the encoding but are only visited with TX_HEADER_EN.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR_H = 3'd1,
        HDR_W = 3'd2,
        READ  = 3'd3,
        WAIT  = 3'd4,
        SEND  = 3'd5
    } state_t;

    localparam logic [7:0] CMD_HEIGHT = 8'h68; // 'h'
    localparam logic [7:0] CMD_WIDTH  = 8'h77; // 'w'
    localparam logic [7:0] CMD_OUTPUT = 8'h6F; // 'o'

endpackage

// File: rtl/tx_mem_streamer.sv
// Streams height*width bytes of the output image memory, address 0 upward,
// to the UART transmitter over a valid/ready handshake.
// Optional macro TX_HEADER_EN: prefix the stream with the height and width bytes.
module tx_mem_streamer
    import filter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DIM_W  = DEF_DIM_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  width,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PROD_W = 2 * DIM_W;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   total;
    logic [ADDR_W-1:0]   addr_inc_c;
    logic [PROD_W-1:0]   prod_c;
`ifdef TX_HEADER_EN
    logic [DIM_W-1:0]    hdr_width;
`endif

    // Full-width byte count and the next pixel address.
    assign prod_c     = PROD_W'(height) * PROD_W'(width);
    assign addr_inc_c = addr + ADDR_W'(1);

    // Streaming FSM with address counter and registered UART/memory outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            total     <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef TX_HEADER_EN
            hdr_width <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total <= ADDR_W'(prod_c);
                        addr  <= '0;
`ifdef TX_HEADER_EN
                        hdr_width <= width;
                        tx_data   <= DATA_W'(height);
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= HDR_H;
`else
                        if (prod_c == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                            state     <= READ;
                        end
`endif
                    end
                end
`ifdef TX_HEADER_EN
                HDR_H: begin
                    if (tx_ready) begin
                        tx_data <= DATA_W'(hdr_width);
                        state   <= HDR_W;
                    end
                end
                HDR_W: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (total == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                            state     <= READ;
                        end
                    end
                end
`endif
                READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    tx_data  <= mem_rd_data;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        addr     <= addr_inc_c;
                        if (addr_inc_c == total) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= addr_inc_c;
                            state     <= READ;
                        end
                    end
                end
                default: begin
                    mem_rd_en <= 1'b0;
                    tx_valid  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_mem_streamer.sv
// Self-checking bench for tx_mem_streamer: directed scenarios plus randomized
// images and UART pacing, compared against a queue-based reference model.
module tb_tx_mem_streamer;
    import filter_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIM_W  = 8;
    localparam int unsigned ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DIM_W-1:0]  height;
    logic [DIM_W-1:0]  width;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              busy;
    logic              done;

    tx_mem_streamer #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .height     (height),
        .width      (width),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Output image memory: synchronous read, data one cycle after the address.
    logic [DATA_W-1:0] mem [0:65535];
    always @(posedge clk) mem_rd_data <= mem[mem_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed traffic, gathered away from the active edge.
    logic [DATA_W-1:0] byte_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int   done_cnt  = 0;
    int   done_cyc  = -1;
    int   stab_err  = 0;
    int   cyc       = 0;
    bit   prev_pend = 0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_pend = 0;
        end else begin
            if (prev_pend && (!tx_valid || tx_data !== prev_data)) stab_err++;
            if (tx_valid && tx_ready) byte_q.push_back(tx_data);
            if (mem_rd_en) addr_q.push_back(mem_addr);
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_pend = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    // UART pacing: 0 = always ready, 1 = ready one cycle in ten, 2 = random.
    int ready_mode = 0;
    int ready_cnt  = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (ready_cnt % 10 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            ready_cnt++;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    int start_cyc = 0;

    task automatic clear_mon();
        byte_q.delete();
        addr_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        stab_err = 0;
    endtask

    task automatic pulse_start(input int h, input int w);
        @(posedge clk);
        #1;
        start     = 1'b1;
        height    = 8'(h);
        width     = 8'(w);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        height = 8'($urandom);
        width  = 8'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Reference: optional header, then mem[0 .. h*w-1] in address order.
    task automatic verify(input string tag, input int h, input int w);
        logic [DATA_W-1:0] exp_q [$];
        int total = h * w;
        int n;
`ifdef TX_HEADER_EN
        exp_q.push_back(8'(h));
        exp_q.push_back(8'(w));
`endif
        for (int i = 0; i < total; i++) exp_q.push_back(mem[i]);
        check({tag, "_nbytes"}, byte_q.size(), exp_q.size());
        n = (byte_q.size() < exp_q.size()) ? byte_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_q[i]));
        check({tag, "_nreads"}, addr_q.size(), total);
        n = (addr_q.size() < total) ? addr_q.size() : total;
        for (int i = 0; i < n; i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), i);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_valid_after"}, 32'(tx_valid), 0);
        check({tag, "_stable"}, stab_err, 0);
    endtask

    task automatic run(input string tag, input int h, input int w, input int mode);
        ready_mode = mode;
        clear_mon();
        pulse_start(h, w);
        wait_done(tag, 20000);
        verify(tag, h, w);
    endtask

    initial begin
        int n;
        rst    = 1'b0;
        start  = 1'b0;
        height = '0;
        width  = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(tx_valid), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(tx_data), 0);
        @(negedge clk);
        rst = 1'b1;

        run("basic", 2, 3, 0);
        run("stall", 2, 3, 1);

        // Empty image
        run("empty", 0, 3, 0);
`ifndef TX_HEADER_EN
        check("empty_done_latency", done_cyc - start_cyc, 2);
`endif

        // Start re-pulsed mid-stream must be ignored
        ready_mode = 0;
        clear_mon();
        pulse_start(2, 3);
        repeat (7) @(posedge clk);
        #1;
        start  = 1'b1;
        height = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("restart", 20000);
        verify("restart", 2, 3);

        // Reset after the third handshake
        clear_mon();
        pulse_start(2, 3);
        n = 0;
        while (byte_q.size() < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach3", byte_q.size(), 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(tx_valid), 0);
        check("midrst_rd_en", 32'(mem_rd_en), 0);
        check("midrst_addr", 32'(mem_addr), 0);
        check("midrst_data", 32'(tx_data), 0);
        check("midrst_done", 32'(done), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        run("after_rst", 1, 1, 0);

        // Randomized images and pacing
        for (int t = 0; t < 10; t++) begin
            int h = $urandom_range(0, 15);
            int w = $urandom_range(0, 15);
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            run($sformatf("rand%0d", t), h, w, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_mem_streamer.md
Name: tx_mem_streamer

Overview:
- Sits between the output image memory and the UART transmitter in the masked 2D filter top.
- When the command decoder receives 'o', it pulses start with the latched height and width.
- The block then reads height*width bytes from the output memory in address order, starting at address 0.
- It hands each byte to the UART TX through a valid/ready handshake and pulses done after the last byte is accepted.

Parameters:
- DATA_W, 8, width of a pixel byte sent over UART
- DIM_W, 8, width of the height and width operands
- ADDR_W, 16, output memory address width; must be >= 2*DIM_W

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse; begin streaming
- height  in  DIM_W  image rows, sampled at start
- width  in  DIM_W  image columns, sampled at start
- mem_rd_en  out  1  output memory read strobe
- mem_addr  out  ADDR_W  output memory read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- tx_data  out  DATA_W  byte offered to the UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX is idle and accepts the byte this cycle
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state=IDLE, counters=0.
- Byte count: total = height*width, computed at full width 2*DIM_W and zero-extended to ADDR_W. It is latched on the start cycle; later changes to height or width are ignored.
- State machine:
  - IDLE: on start, go to READ with addr=0. If total==0, skip READ and pulse done the next cycle (busy stays 0).
  - READ: mem_rd_en=1 for one cycle with mem_addr=addr; go to WAIT.
  - WAIT: capture mem_rd_data into the tx_data register; set tx_valid=1; go to SEND.
  - SEND: hold tx_valid and tx_data stable until tx_ready=1.
    - On the handshake cycle, tx_valid drops the next cycle and addr increments.
    - If addr+1 == total: go to IDLE and pulse done.
    - Otherwise: go to READ.
- busy=1 in every state except IDLE.
- tx_valid never depends combinationally on tx_ready.
- Throughput: at most one byte per 3 cycles. UART pacing is set entirely by tx_ready.
- start while busy is ignored; it does not restart the stream or relatch dimensions.
- tx_ready while tx_valid=0 is ignored.
- Maximum image 255x255 = 65025 bytes; addr does not wrap for ADDR_W=16.
- Reset mid-stream: returns to IDLE immediately and emits no done pulse. A partial byte may already be in the UART and is not recalled.

Optional Feature:
- Macro TX_HEADER_EN.
- Defined: before the pixel data, the stream emits two header bytes, height then width. Each header byte uses the same valid/ready handshake, and no memory read occurs for the header. With total==0 the two header bytes are still sent, then done pulses.
- Undefined: only pixel bytes are sent. No header states or logic exist.

Decomposition:
- Shared package filter_pkg holds:
  - DATA_W, DIM_W and ADDR_W defaults
  - the state enum (IDLE, HDR_H, HDR_W, READ, WAIT, SEND)
  - the command byte constants ('h','w','o'), shared with the command decoder.
- No sub-module; a single FSM with an address counter and a byte register is sufficient.

Test Plan:
- height=2, width=3, mem[i]=i, tx_ready tied to 1: bytes 0,1,2,3,4,5 in order, mem_addr 0..5, exactly 6 handshakes, done pulses once, busy low afterwards.
- Same image with tx_ready high only 1 cycle in every 10: tx_data and tx_valid stay stable during stalls, and the sequence is unchanged.
- height=0, width=3: no mem_rd_en and no tx_valid; done pulses 1 cycle after start.
- start re-pulsed mid-stream with height=5: ignored; still exactly 6 bytes, and done pulses once.
- rst asserted after the 3rd handshake: outputs are 0 immediately. A fresh start with height=1, width=1 sends mem[0]=0 and pulses done.
- TX_HEADER_EN defined, height=2, width=3: byte stream is 2,3,0,1,2,3,4,5, then done.
